// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - operand forwarding, load-use interlock and redirect flush control
module pipe_hazard_ctrl #(
    parameter int AW             = 5,
    parameter int DEPTH          = 3,
    parameter int LOAD_USE_STALL = 1,
    parameter int DELAY_SLOT     = 1,
    parameter int CNT_W          = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           id_valid,
    input  logic [AW-1:0]                  id_rs,
    input  logic [AW-1:0]                  id_rt,
    input  logic                           id_rs_used,
    input  logic                           id_rt_used,
    input  logic [AW-1:0]                  id_dst,
    input  logic                           id_regwr,
    input  logic                           id_is_load,
    input  logic                           ex_redirect,
    input  logic                           cnt_clr,
    output logic [$clog2(DEPTH+1)-1:0]     fwd_a,
    output logic [$clog2(DEPTH+1)-1:0]     fwd_b,
    output logic                           stall,
    output logic                           flush,
    output logic                           hazard_err,
    output logic [CNT_W-1:0]               stall_cnt
);
    localparam int SELW = $clog2(DEPTH+1);

    // Shadow pipeline: index 1 is the stage right after decode (EX).
    logic [DEPTH:1] sh_v;
    logic [DEPTH:1] sh_regwr;
    logic [DEPTH:1] sh_ld;
    logic [AW-1:0]  sh_dst [1:DEPTH];

    logic [DEPTH:1] match_a;
    logic [DEPTH:1] match_b;
    logic           load_use;

    always_comb begin
        match_a = '0;
        match_b = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            match_a[k] = sh_v[k] & sh_regwr[k] & (sh_dst[k] == id_rs) & (id_rs != '0);
            match_b[k] = sh_v[k] & sh_regwr[k] & (sh_dst[k] == id_rt) & (id_rt != '0);
        end
    end

    // Scan oldest to youngest so the youngest producer overwrites the select.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (match_a[k] && id_rs_used) fwd_a = SELW'(k);
            if (match_b[k] && id_rt_used) fwd_b = SELW'(k);
        end
    end

    assign load_use = id_valid & sh_v[1] & sh_ld[1] &
                      ((match_a[1] & id_rs_used) | (match_b[1] & id_rt_used));

    assign flush      = (DELAY_SLOT == 0) ? (ex_redirect & id_valid) : 1'b0;
    assign stall      = (LOAD_USE_STALL != 0) ? (load_use & ~flush) : 1'b0;
    assign hazard_err = (LOAD_USE_STALL == 0) ? load_use : 1'b0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_v      <= '0;
            sh_regwr  <= '0;
            sh_ld     <= '0;
            for (int k = 1; k <= DEPTH; k++) sh_dst[k] <= '0;
            stall_cnt <= '0;
        end else begin
            sh_v[1]     <= id_valid & ~stall & ~flush;
            sh_regwr[1] <= id_regwr;
            sh_ld[1]    <= id_is_load;
            sh_dst[1]   <= id_dst;
            sh_v[DEPTH:2]     <= sh_v[DEPTH-1:1];
            sh_regwr[DEPTH:2] <= sh_regwr[DEPTH-1:1];
            sh_ld[DEPTH:2]    <= sh_ld[DEPTH-1:1];
            for (int k = 2; k <= DEPTH; k++) sh_dst[k] <= sh_dst[k-1];
            if (cnt_clr)
                stall_cnt <= '0;
            else if (stall && !(&stall_cnt))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - randomized and directed checks of pipe_hazard_ctrl against a reference model
module tb_pipe_hazard_ctrl;
    localparam int D  = 3;
    localparam int CW = 4;
    localparam int NC = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic id_valid = 1'b0, id_rs_used = 1'b0, id_rt_used = 1'b0;
    logic id_regwr = 1'b0, id_is_load = 1'b0, ex_redirect = 1'b0, cnt_clr = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0, id_dst = '0;

    logic [1:0]    fa  [NC];
    logic [1:0]    fb  [NC];
    logic          st  [NC];
    logic          fl  [NC];
    logic          he  [NC];
    logic [CW-1:0] cnt [NC];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    // Configs: 0 = interlock + delay slot, 1 = software rule + flush, 2 = interlock + flush
    pipe_hazard_ctrl #(.AW(5), .DEPTH(D), .LOAD_USE_STALL(1), .DELAY_SLOT(1), .CNT_W(CW)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst), .id_regwr(id_regwr),
        .id_is_load(id_is_load), .ex_redirect(ex_redirect), .cnt_clr(cnt_clr),
        .fwd_a(fa[0]), .fwd_b(fb[0]), .stall(st[0]), .flush(fl[0]), .hazard_err(he[0]),
        .stall_cnt(cnt[0]));
    pipe_hazard_ctrl #(.AW(5), .DEPTH(D), .LOAD_USE_STALL(0), .DELAY_SLOT(0), .CNT_W(CW)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst), .id_regwr(id_regwr),
        .id_is_load(id_is_load), .ex_redirect(ex_redirect), .cnt_clr(cnt_clr),
        .fwd_a(fa[1]), .fwd_b(fb[1]), .stall(st[1]), .flush(fl[1]), .hazard_err(he[1]),
        .stall_cnt(cnt[1]));
    pipe_hazard_ctrl #(.AW(5), .DEPTH(D), .LOAD_USE_STALL(1), .DELAY_SLOT(0), .CNT_W(CW)) dut2 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dst(id_dst), .id_regwr(id_regwr),
        .id_is_load(id_is_load), .ex_redirect(ex_redirect), .cnt_clr(cnt_clr),
        .fwd_a(fa[2]), .fwd_b(fb[2]), .stall(st[2]), .flush(fl[2]), .hazard_err(he[2]),
        .stall_cnt(cnt[2]));

    // Reference model: list of in-flight instructions per config, position 1 = youngest.
    bit mv [NC][1:D];
    bit mw [NC][1:D];
    bit ml [NC][1:D];
    int md [NC][1:D];
    int mc [NC];

    function automatic bit cfg_interlock(input int c);
        return c != 1;
    endfunction

    function automatic bit cfg_flush(input int c);
        return c != 0;
    endfunction

    function automatic bit produces(input int c, input int k, input int r);
        return mv[c][k] && mw[c][k] && md[c][k] == r && r != 0;
    endfunction

    function automatic void model_out(input int c, output int ea, output int eb,
                                      output int es, output int ef, output int eh);
        bit lu;
        ea = 0;
        eb = 0;
        for (int k = 1; k <= D; k++) begin
            if (ea == 0 && id_rs_used && produces(c, k, int'(id_rs))) ea = k;
            if (eb == 0 && id_rt_used && produces(c, k, int'(id_rt))) eb = k;
        end
        lu = id_valid && mv[c][1] && ml[c][1] &&
             ((id_rs_used && produces(c, 1, int'(id_rs))) ||
              (id_rt_used && produces(c, 1, int'(id_rt))));
        ef = (cfg_flush(c) && ex_redirect && id_valid) ? 1 : 0;
        es = (cfg_interlock(c) && lu && ef == 0) ? 1 : 0;
        eh = (!cfg_interlock(c) && lu) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        int ea, eb, es, ef, eh;
        if (!rst) begin
            for (int c = 0; c < NC; c++) begin
                for (int k = 1; k <= D; k++) begin
                    mv[c][k] <= 1'b0;
                    mw[c][k] <= 1'b0;
                    ml[c][k] <= 1'b0;
                    md[c][k] <= 0;
                end
                mc[c] <= 0;
            end
        end else begin
            for (int c = 0; c < NC; c++) begin
                model_out(c, ea, eb, es, ef, eh);
                for (int k = 2; k <= D; k++) begin
                    mv[c][k] <= mv[c][k-1];
                    mw[c][k] <= mw[c][k-1];
                    ml[c][k] <= ml[c][k-1];
                    md[c][k] <= md[c][k-1];
                end
                mv[c][1] <= id_valid && es == 0 && ef == 0;
                mw[c][1] <= id_regwr;
                ml[c][1] <= id_is_load;
                md[c][1] <= int'(id_dst);
                if (cnt_clr)
                    mc[c] <= 0;
                else if (es != 0 && mc[c] < (1 << CW) - 1)
                    mc[c] <= mc[c] + 1;
            end
        end
    end

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d got=%0d want=%0d at %0t", nm, c, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        int ea, eb, es, ef, eh;
        if (rst) begin
            for (int c = 0; c < NC; c++) begin
                model_out(c, ea, eb, es, ef, eh);
                chk("m_fwd_a", c, 32'(fa[c]), ea);
                chk("m_fwd_b", c, 32'(fb[c]), eb);
                chk("m_stall", c, 32'(st[c]), es);
                chk("m_flush", c, 32'(fl[c]), ef);
                chk("m_herr", c, 32'(he[c]), eh);
                chk("m_cnt", c, 32'(cnt[c]), mc[c]);
            end
        end
    end

    task automatic put(input int v, input int rs, input int rt, input int rsu, input int rtu,
                       input int dst, input int wr, input int ld, input int rd);
        @(posedge clk);
        #2;
        id_valid    = v[0];
        id_rs       = rs[4:0];
        id_rt       = rt[4:0];
        id_rs_used  = rsu[0];
        id_rt_used  = rtu[0];
        id_dst      = dst[4:0];
        id_regwr    = wr[0];
        id_is_load  = ld[0];
        ex_redirect = rd[0];
    endtask

    task automatic all_zero(input string nm);
        for (int c = 0; c < NC; c++) begin
            chk({nm, "_fwd_a"}, c, 32'(fa[c]), 0);
            chk({nm, "_fwd_b"}, c, 32'(fb[c]), 0);
            chk({nm, "_stall"}, c, 32'(st[c]), 0);
            chk({nm, "_flush"}, c, 32'(fl[c]), 0);
            chk({nm, "_herr"}, c, 32'(he[c]), 0);
            chk({nm, "_cnt"}, c, 32'(cnt[c]), 0);
        end
    endtask

    initial begin
        id_valid = 1'b1; id_rs = 5'd2; id_rs_used = 1'b1; id_is_load = 1'b1;
        repeat (3) @(negedge clk);
        all_zero("reset");
        #3 rst = 1'b1;

        // Back-to-back ALU dependency, distances 1..4
        put(1, 1, 0, 1, 0, 3, 1, 0, 0);
        put(1, 3, 5, 1, 1, 4, 1, 0, 0);
        @(negedge clk); for (int c = 0; c < NC; c++) chk("alu_d1", c, 32'(fa[c]), 1);
        put(1, 3, 0, 1, 0, 8, 1, 0, 0);
        @(negedge clk); for (int c = 0; c < NC; c++) chk("alu_d2", c, 32'(fa[c]), 2);
        put(1, 3, 0, 1, 0, 10, 1, 0, 0);
        @(negedge clk); chk("alu_d3", 0, 32'(fa[0]), 3);
        put(1, 3, 0, 1, 0, 12, 1, 0, 0);
        @(negedge clk); chk("alu_d4", 0, 32'(fa[0]), 0); chk("alu_d4_stall", 0, 32'(st[0]), 0);

        // Double producer, and writes to $0
        put(1, 1, 0, 1, 0, 3, 1, 0, 0);
        put(1, 1, 0, 1, 0, 3, 1, 0, 0);
        put(1, 3, 3, 1, 1, 6, 1, 0, 0);
        @(negedge clk); chk("young_a", 0, 32'(fa[0]), 1); chk("young_b", 0, 32'(fb[0]), 1);
        put(1, 1, 0, 1, 0, 0, 1, 0, 0);
        put(1, 0, 0, 1, 1, 6, 1, 0, 0);
        @(negedge clk); chk("r0_a", 0, 32'(fa[0]), 0); chk("r0_b", 0, 32'(fb[0]), 0);

        // Load-use
        put(1, 1, 0, 1, 0, 2, 1, 1, 0);
        put(1, 2, 0, 1, 0, 7, 1, 0, 0);
        @(negedge clk);
        chk("lu_stall", 0, 32'(st[0]), 1); chk("lu_fwd1", 0, 32'(fa[0]), 1);
        chk("lu_sw_stall", 1, 32'(st[1]), 0); chk("lu_sw_herr", 1, 32'(he[1]), 1);
        chk("lu_sw_fwd1", 1, 32'(fa[1]), 1); chk("lu_hw_herr", 0, 32'(he[0]), 0);
        put(1, 2, 0, 1, 0, 7, 1, 0, 0);
        @(negedge clk);
        chk("lu_after_stall", 0, 32'(st[0]), 0); chk("lu_fwd2", 0, 32'(fa[0]), 2);
        chk("lu_cnt", 0, 32'(cnt[0]), 1); chk("lu_sw_herr2", 1, 32'(he[1]), 0);

        // Redirect
        put(1, 0, 0, 0, 0, 9, 1, 0, 1);
        @(negedge clk);
        chk("rd_ds_flush", 0, 32'(fl[0]), 0); chk("rd_nods_flush", 1, 32'(fl[1]), 1);
        put(1, 9, 0, 1, 0, 11, 1, 0, 0);
        @(negedge clk);
        chk("rd_ds_enter", 0, 32'(fa[0]), 1); chk("rd_nods_bubble", 2, 32'(fa[2]), 0);
        put(1, 0, 0, 0, 0, 2, 1, 1, 0);
        put(1, 2, 0, 1, 0, 7, 1, 0, 1);
        @(negedge clk);
        chk("rdlu_flush", 2, 32'(fl[2]), 1); chk("rdlu_stall", 2, 32'(st[2]), 0);
        chk("rdlu_ds_stall", 0, 32'(st[0]), 1);

        // Saturation: self-dependent loads stall every other cycle
        for (int i = 0; i < 40; i++) put(1, 2, 0, 1, 0, 2, 1, 1, 0);
        @(negedge clk);
        chk("sat0", 0, 32'(cnt[0]), 15); chk("sat2", 2, 32'(cnt[2]), 15);
        chk("sat_sw", 1, 32'(cnt[1]), 0);
        put(1, 2, 0, 1, 0, 2, 1, 1, 0); cnt_clr = 1'b1;
        put(1, 2, 0, 1, 0, 2, 1, 1, 0); cnt_clr = 1'b0;
        @(negedge clk); chk("clr", 0, 32'(cnt[0]), 0);

        // Reset while stalling
        for (int i = 0; i < 4 && st[0] !== 1'b1; i++) @(negedge clk);
        chk("pre_rst_stall", 0, 32'(st[0]), 1);
        #1 rst = 1'b0;
        #1 all_zero("async_rst");
        #1 rst = 1'b1;
        #1 chk("post_rst_fwd", 0, 32'(fa[0]), 0); chk("post_rst_stall", 0, 32'(st[0]), 0);

        // Randomized phase, checked by the compare process
        for (int i = 0; i < 3000; i++) begin
            put(($urandom % 8) != 0, $urandom % 6, $urandom % 6, $urandom % 2, $urandom % 2,
                $urandom % 6, $urandom % 4 != 0, $urandom % 3 == 0, $urandom % 6 == 0);
            cnt_clr = ($urandom % 60) == 0;
        end
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
